pm_traceback: RTL
=================

Name: pm_traceback

Overview:
- Consumer end of the path-metric/decision pipeline in the pipelined Viterbi decoder (K=3, 4 trellis states).
- Accepts the per-state survivor decision stream (dec, addr, data_id, term) emitted by the PM memory stage and stores one frame of decisions.
- On frame termination it traces back from state 0 (zero-tailed trellis), reverses the result, and streams decoded bits out in forward order over a valid/ready handshake.

Parameters:
- MAX_STEPS, 32, maximum trellis steps per frame, tail included.
- TAIL, 2, zero-tail steps (K-1); these are removed from the output.

Ports:
- PM_clk  in  1  clock.
- PM_rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decision beat valid.
- dec_in  in  1  survivor decision bit for state addr_in.
- addr_in  in  2  trellis state index of this beat.
- term_in  in  1  last trellis step of the frame; sampled only on the addr_in==3 beat.
- data_id_in  in  3  frame tag.
- bit_out  out  1  decoded bit.
- bit_valid  out  1  bit_out valid.
- bit_ready  in  1  downstream accepts the bit.
- bit_last  out  1  last decoded bit of the frame.
- data_id_out  out  3  tag of the frame being emitted.
- busy  out  1  high in TRACE/EMIT; input beats are not accepted.
- drop_err  out  1  1-cycle pulse: in_valid seen while busy; the beat is dropped.
- ovf_err  out  1  1-cycle pulse: MAX_STEPS reached without term; trace is forced.

Behaviour:
- Reset values (async, PM_rst low): all outputs 0, FSM=COLLECT, step count 0, decision store cleared. Reset mid-frame aborts the frame; no partial output.
- Storage: surv[MAX_STEPS][4] decision flops and obuf[MAX_STEPS] bits.

COLLECT:
- Valid beat writes surv[step][addr_in] <= dec_in.
- Beats may arrive in any addr order. A step completes on the valid addr_in==3 beat, then step increments.
- data_id_in is captured on the first beat of a frame into data_id_out.
- Frame end (the step with addr==3): term_in=1, or step+1==MAX_STEPS. In the latter case, if term_in=0, pulse ovf_err.
- On frame end: N <= step+1, enter TRACE next cycle.

TRACE:
- Starts with s=0 at k=N-1; one step per cycle, N cycles total.
- Each cycle: obuf[k] <= s[1]; d = surv[k][s]; s <= {s[0], d}; k--.
- After k=0, enter EMIT.
- If N<=TAIL, skip EMIT and return to COLLECT with step=0 (no bits emitted).

EMIT:
- bit_out = obuf[j] for j = 0..N-TAIL-1; bit_valid=1.
- j advances only on bit_valid & bit_ready. bit_out and bit_valid hold stable while bit_ready is low.
- bit_last=1 when j==N-TAIL-1.
- After the last accepted beat: bit_valid=0, step=0, return to COLLECT.

Other rules:
- busy=1 in TRACE and EMIT.
- in_valid while busy: beat is ignored and drop_err pulses. This includes the cycle of the frame-end transition itself, i.e. busy is registered from the next cycle.
- Latency from the term beat to the first bit_valid: N+1 cycles.

Decomposition:
- Shared package holds: FSM state enum (COLLECT, TRACE, EMIT), NUM_STATES=4, and a predecessor function pred(s,d)={s[0],d}.
- One sub-module is natural: pm_tb_store (decision flop array with write port and async read by [k][s]).

Test Plan:
- Message 1,0,1,1 with tail 0,0. Per step, write 1 to state (10,01,10,11,01,00) with decisions (0,0,1,0,1,1) and 0 to all other states; term on step 5; data_id=5 -> bits 1,0,1,1 with bit_last on the 4th bit and data_id_out=5; first bit_valid 7 cycles after the term beat.
- Same frame with bit_ready toggling 1,0,0,1 -> bit_out holds while bit_ready=0; no bit lost or duplicated.
- 32 steps with term_in=0 throughout -> ovf_err pulses once; 30 bits emitted.
- in_valid asserted during EMIT -> drop_err pulses per beat; the next frame decodes correctly.
- Frame of 2 steps (N=TAIL) -> no bit_valid; busy high for 2 cycles, then COLLECT.
- PM_rst low mid-TRACE -> outputs 0 immediately; a fresh frame afterwards decodes correctly.

Source files
------------

// File: rtl/pm_traceback_pkg.sv
// Shared types and helpers for the Viterbi traceback stage (K=3, four trellis states).
package pm_traceback_pkg;

    localparam int NUM_STATES = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        TRACE   = 2'd1,
        EMIT    = 2'd2
    } pm_state_t;

    // Newest input bit sits in s[1]; the survivor decision supplies the bit shifted out.
    function automatic logic [1:0] pred(input logic [1:0] s, input logic d);
        return {s[0], d};
    endfunction

endpackage

// File: rtl/pm_traceback_store.sv
// Survivor decision store: one bit per (trellis step, state), written per beat, read asynchronously.
module pm_tb_store
    import pm_traceback_pkg::*;
#(
    parameter int MAX_STEPS = 32,
    parameter int KW        = $clog2(MAX_STEPS)
)
(
    input  logic          PM_clk,
    input  logic          PM_rst,
    input  logic          i_wrEn,
    input  logic [KW-1:0] i_wrStep,
    input  logic [1:0]    i_wrState,
    input  logic          i_wrDec,
    input  logic [KW-1:0] i_rdStep,
    input  logic [1:0]    i_rdState,
    output logic          o_rdDec
);

    logic [NUM_STATES-1:0] r_surv [MAX_STEPS];

    always_ff @(posedge PM_clk or negedge PM_rst) begin
        if (!PM_rst) begin
            for (int i = 0; i < MAX_STEPS; i++) begin
                r_surv[i] <= '0;
            end
        end else if (i_wrEn) begin
            r_surv[i_wrStep][i_wrState] <= i_wrDec;
        end
    end

    assign o_rdDec = r_surv[i_rdStep][i_rdState];

endmodule

// File: rtl/pm_traceback.sv
// Viterbi traceback: collects one frame of survivor decisions, traces back from state 0,
// and streams the decoded bits (tail removed) in forward order over valid/ready.
module pm_traceback
    import pm_traceback_pkg::*;
#(
    parameter int MAX_STEPS = 32,
    parameter int TAIL      = 2
)
(
    input  logic       PM_clk,
    input  logic       PM_rst,
    input  logic       in_valid,
    input  logic       dec_in,
    input  logic [1:0] addr_in,
    input  logic       term_in,
    input  logic [2:0] data_id_in,
    output logic       bit_out,
    output logic       bit_valid,
    input  logic       bit_ready,
    output logic       bit_last,
    output logic [2:0] data_id_out,
    output logic       busy,
    output logic       drop_err,
    output logic       ovf_err
);

    localparam int KW = $clog2(MAX_STEPS);
    localparam int NW = $clog2(MAX_STEPS + 1);

    pm_state_t            r_state;
    pm_state_t            w_nextState;
    logic [KW-1:0]        r_step;
    logic [KW-1:0]        r_k;
    logic [KW-1:0]        r_j;
    logic [NW-1:0]        r_n;
    logic [1:0]           r_s;
    logic [MAX_STEPS-1:0] r_obuf;
    logic [2:0]           r_dataId;
    logic                 r_frameOpen;
    logic                 r_dropErr;
    logic                 r_ovfErr;

    logic                 w_beat;
    logic                 w_stepDone;
    logic                 w_atLimit;
    logic                 w_frameEnd;
    logic                 w_traceDone;
    logic                 w_emitFire;
    logic                 w_emitDone;
    logic                 w_survDec;
    logic [NW-1:0]        w_stepCount;
    logic [NW-1:0]        w_lastIdx;

    assign w_beat      = in_valid && (r_state == COLLECT);
    assign w_stepDone  = w_beat && (addr_in == 2'd3);
    assign w_stepCount = NW'(r_step) + NW'(1);
    assign w_atLimit   = (w_stepCount == NW'(MAX_STEPS));
    assign w_frameEnd  = w_stepDone && (term_in || w_atLimit);
    assign w_traceDone = (r_state == TRACE) && (r_k == '0);
    assign w_lastIdx   = r_n - NW'(TAIL + 1);
    assign w_emitFire  = (r_state == EMIT) && bit_ready;
    assign w_emitDone  = w_emitFire && (NW'(r_j) == w_lastIdx);

    pm_tb_store #(
        .MAX_STEPS (MAX_STEPS),
        .KW        (KW)
    ) u_store (
        .PM_clk    (PM_clk),
        .PM_rst    (PM_rst),
        .i_wrEn    (w_beat),
        .i_wrStep  (r_step),
        .i_wrState (addr_in),
        .i_wrDec   (dec_in),
        .i_rdStep  (r_k),
        .i_rdState (r_s),
        .o_rdDec   (w_survDec)
    );

    always_ff @(posedge PM_clk or negedge PM_rst) begin
        if (!PM_rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Frames of TAIL steps or fewer carry no payload, so EMIT is skipped for them.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            COLLECT: if (w_frameEnd)  w_nextState = TRACE;
            TRACE:   if (w_traceDone) w_nextState = (r_n > NW'(TAIL)) ? EMIT : COLLECT;
            EMIT:    if (w_emitDone)  w_nextState = COLLECT;
            default:                  w_nextState = COLLECT;
        endcase
    end

    always_comb begin
        busy        = (r_state != COLLECT);
        bit_valid   = (r_state == EMIT);
        bit_out     = (r_state == EMIT) && r_obuf[r_j];
        bit_last    = (r_state == EMIT) && (NW'(r_j) == w_lastIdx);
        data_id_out = r_dataId;
        drop_err    = r_dropErr;
        ovf_err     = r_ovfErr;
    end

    // Step counter and frame tag are rearmed at frame end; the tag output holds until the next frame's first beat.
    always_ff @(posedge PM_clk or negedge PM_rst) begin
        if (!PM_rst) begin
            r_step      <= '0;
            r_k         <= '0;
            r_j         <= '0;
            r_n         <= '0;
            r_s         <= '0;
            r_obuf      <= '0;
            r_dataId    <= '0;
            r_frameOpen <= 1'b0;
            r_dropErr   <= 1'b0;
            r_ovfErr    <= 1'b0;
        end else begin
            r_dropErr <= in_valid && (r_state != COLLECT);
            r_ovfErr  <= w_frameEnd && !term_in;
            unique case (r_state)
                COLLECT: begin
                    if (w_beat && !r_frameOpen) begin
                        r_dataId    <= data_id_in;
                        r_frameOpen <= 1'b1;
                    end
                    if (w_frameEnd) begin
                        r_n         <= w_stepCount;
                        r_k         <= r_step;
                        r_s         <= '0;
                        r_j         <= '0;
                        r_step      <= '0;
                        r_frameOpen <= 1'b0;
                    end else if (w_stepDone) begin
                        r_step <= r_step + KW'(1);
                    end
                end
                TRACE: begin
                    r_obuf[r_k] <= r_s[1];
                    r_s         <= pred(r_s, w_survDec);
                    r_k         <= r_k - KW'(1);
                end
                EMIT: begin
                    if (w_emitFire) begin
                        r_j <= r_j + KW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
